// File: rtl/buffered_matrixn_grayscale_converter.sv
// buffered_matrixn_grayscale_converter: converts an RGB raster stream to grayscale and slides an N x N window over it
// Ports: I_CLK clock; I_RESET asynchronous active-low reset; I_DATA_VALID pixel strobe;
//   I_FRAME_SYNC marks the accepted pixel as (row 0, col 0); I_PIXEL {R,G,B} with R in the MSBs;
//   O_PIXEL_COLUMN / O_PIXEL_ROW window-centre coordinates; O_PIXEL_MATRIX packed gray window,
//   element (r,c) at [(r*N+c)*D +: D], r=0 oldest line, c=0 oldest column; O_PIXEL_MATRIX_READY one-cycle pulse.
// Optional: define GRAYSCALE_ROUNDING_EN for rounded and saturated luma instead of truncated luma.
module buffered_matrixn_grayscale_converter #(
  parameter int P_FRAME_COLUMNS = 640,
  parameter int P_FRAME_ROWS = 480,
  parameter int P_PIXEL_DEPTH = 24,
  parameter int P_MATRIX_SIZE = 3,
  localparam int P_SUBPIXEL_DEPTH = P_PIXEL_DEPTH / 3,
  localparam int CW = (P_FRAME_COLUMNS > 1) ? $clog2(P_FRAME_COLUMNS) : 1,
  localparam int RW = (P_FRAME_ROWS > 1) ? $clog2(P_FRAME_ROWS) : 1
) (
  input  logic                                                   I_CLK,
  input  logic                                                   I_RESET,
  input  logic                                                   I_DATA_VALID,
  input  logic                                                   I_FRAME_SYNC,
  input  logic [P_PIXEL_DEPTH-1:0]                               I_PIXEL,
  output logic [CW-1:0]                                          O_PIXEL_COLUMN,
  output logic [RW-1:0]                                          O_PIXEL_ROW,
  output logic [P_MATRIX_SIZE*P_MATRIX_SIZE*P_SUBPIXEL_DEPTH-1:0] O_PIXEL_MATRIX,
  output logic                                                   O_PIXEL_MATRIX_READY
);
  localparam int D = P_SUBPIXEL_DEPTH;
  localparam int N = P_MATRIX_SIZE;
  localparam int SW = (D + 9 > 2 * D + 1) ? D + 9 : 2 * D + 1;
`ifdef GRAYSCALE_ROUNDING_EN
  localparam int RND = 128;
`else
  localparam int RND = 0;
`endif
  logic [CW-1:0] col_q, col_d, cur_col, s1_col_q, s1_col_d, ocol_q, ocol_d;
  logic [RW-1:0] row_q, row_d, cur_row, s1_row_q, s1_row_d, orow_q, orow_d;
  logic [D-1:0] y, s1_y_q, s1_y_d;
  logic [SW-1:0] sum;
  logic col_last, s1_valid_q, s1_valid_d, ready_q, ready_d;
  logic [N*N*D-1:0] win_q, win_d;
  logic [D-1:0] new_col [N];
  logic [D-1:0] lb_mem [N-1][P_FRAME_COLUMNS];
  // Stage 1: position tracking and luma conversion of the accepted pixel
  always_comb begin
    cur_col = I_FRAME_SYNC ? '0 : col_q;
    cur_row = I_FRAME_SYNC ? '0 : row_q;
    col_last = cur_col == CW'(P_FRAME_COLUMNS - 1);
    col_d = !I_DATA_VALID ? col_q : col_last ? '0 : cur_col + 1'b1;
    row_d = !I_DATA_VALID ? row_q : !col_last ? cur_row :
            (cur_row == RW'(P_FRAME_ROWS - 1)) ? '0 : cur_row + 1'b1;
    sum = SW'(77) * SW'(I_PIXEL[3*D-1 -: D]) + SW'(150) * SW'(I_PIXEL[2*D-1 -: D]) +
          SW'(29) * SW'(I_PIXEL[D-1:0]) + SW'(RND);
    y = ((sum >> 8) > SW'({D{1'b1}})) ? '1 : D'(sum >> 8);
    s1_valid_d = I_DATA_VALID;
    s1_y_d = I_DATA_VALID ? y : s1_y_q;
    s1_col_d = I_DATA_VALID ? cur_col : s1_col_q;
    s1_row_d = I_DATA_VALID ? cur_row : s1_row_q;
  end
  // Stage 2: new window column is the same column of every buffered line (oldest first) plus the new luma
  always_comb begin
    for (int r = 0; r < N - 1; r++) new_col[r] = lb_mem[N-2-r][s1_col_q];
    new_col[N-1] = s1_y_q;
    win_d = win_q;
    if (s1_valid_q)
      for (int r = 0; r < N; r++) begin
        for (int c = 0; c < N - 1; c++) win_d[(r*N+c)*D +: D] = win_q[(r*N+c+1)*D +: D];
        win_d[(r*N+N-1)*D +: D] = new_col[r];
      end
    ready_d = s1_valid_q && s1_row_q >= RW'(N - 1) && s1_col_q >= CW'(N - 1);
    ocol_d = ready_d ? s1_col_q - CW'((N - 1) / 2) : ocol_q;
    orow_d = ready_d ? s1_row_q - RW'((N - 1) / 2) : orow_q;
  end
  always_ff @(posedge I_CLK or negedge I_RESET)
    if (!I_RESET) begin
      col_q <= '0;
      row_q <= '0;
      s1_valid_q <= 1'b0;
      s1_y_q <= '0;
      s1_col_q <= '0;
      s1_row_q <= '0;
      win_q <= '0;
      ready_q <= 1'b0;
      ocol_q <= '0;
      orow_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
      s1_valid_q <= s1_valid_d;
      s1_y_q <= s1_y_d;
      s1_col_q <= s1_col_d;
      s1_row_q <= s1_row_d;
      win_q <= win_d;
      ready_q <= ready_d;
      ocol_q <= ocol_d;
      orow_q <= orow_d;
    end
  // Line buffers form a chain per column: each write pushes that column's older lines one buffer deeper
  always_ff @(posedge I_CLK)
    if (s1_valid_q) begin
      lb_mem[0][s1_col_q] <= s1_y_q;
      for (int k = 1; k < N - 1; k++) lb_mem[k][s1_col_q] <= lb_mem[k-1][s1_col_q];
    end
  assign O_PIXEL_COLUMN = ocol_q;
  assign O_PIXEL_ROW = orow_q;
  assign O_PIXEL_MATRIX = win_q;
  assign O_PIXEL_MATRIX_READY = ready_q;
endmodule

// File: tb/tb_buffered_matrixn_grayscale_converter.sv
// tb_buffered_matrixn_grayscale_converter: randomized scoreboard bench for the grayscale window converter
module tb_buffered_matrixn_grayscale_converter;
  localparam int COLS = 8;
  localparam int ROWS = 6;
  localparam int N = 3;
  typedef struct {
    int cyc;
    int row;
    int col;
    logic [71:0] mat;
  } ev_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic vld = 1'b0;
  logic fsync = 1'b0;
  logic [23:0] pix = '0;
  logic [2:0] o_col;
  logic [2:0] o_row;
  logic [71:0] o_mat;
  logic o_rdy;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int pulses = 0;
  int hold_row = 0;
  int hold_col = 0;
  int mr = 0;
  int mc = 0;
  int img [ROWS][COLS];
  logic mon_en = 1'b0;
  logic exp_now;
  ev_t q[$];

  buffered_matrixn_grayscale_converter #(
    .P_FRAME_COLUMNS(COLS),
    .P_FRAME_ROWS(ROWS),
    .P_PIXEL_DEPTH(24),
    .P_MATRIX_SIZE(N)
  ) dut (
    .I_CLK(clk),
    .I_RESET(rst_n),
    .I_DATA_VALID(vld),
    .I_FRAME_SYNC(fsync),
    .I_PIXEL(pix),
    .O_PIXEL_COLUMN(o_col),
    .O_PIXEL_ROW(o_row),
    .O_PIXEL_MATRIX(o_mat),
    .O_PIXEL_MATRIX_READY(o_rdy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  task automatic chk(string tag, logic [71:0] got, logic [71:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h at cycle %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic int gray(logic [23:0] p);
    int s;
    s = 77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0]);
`ifdef GRAYSCALE_ROUNDING_EN
    s = (s + 128) / 256;
    return (s > 255) ? 255 : s;
`else
    return (s / 256) % 256;
`endif
  endfunction

  // Reference: remember every pixel of the frame by position and predict each full window
  task automatic drive(bit v, bit s, logic [23:0] p);
    ev_t e;
    @(negedge clk);
    vld = v;
    fsync = s;
    pix = p;
    if (v) begin
      if (s) begin
        mr = 0;
        mc = 0;
      end
      img[mr][mc] = gray(p);
      if (mr >= N - 1 && mc >= N - 1) begin
        e.cyc = cyc + 2;
        e.row = mr - (N - 1) / 2;
        e.col = mc - (N - 1) / 2;
        e.mat = '0;
        for (int i = 0; i < N; i++)
          for (int j = 0; j < N; j++)
            e.mat[(i*N+j)*8 +: 8] = 8'(img[mr-(N-1)+i][mc-(N-1)+j]);
        q.push_back(e);
      end
      mc++;
      if (mc == COLS) begin
        mc = 0;
        mr = (mr + 1) % ROWS;
      end
    end
  endtask

  task automatic idle(int n);
    for (int k = 0; k < n; k++) drive(0, 0, 24'($urandom));
  endtask

  task automatic run_frame(int kind, bit tog);
    logic [23:0] p;
    logic [7:0] cb;
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++) begin
        cb = 8'(c);
        p = (kind == 0) ? 24'hFFFFFF : (kind == 1) ? 24'hFF0000 :
            (kind == 2) ? {cb, cb, cb} : 24'($urandom);
        drive(1, r == 0 && c == 0, p);
        if (tog) drive(0, 0, 24'($urandom));
      end
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_rdy"}, 72'(o_rdy), 72'd0);
    chk({tag, "_col"}, 72'(o_col), 72'd0);
    chk({tag, "_row"}, 72'(o_row), 72'd0);
    chk({tag, "_mat"}, o_mat, 72'd0);
  endtask

  always @(negedge clk)
    if (mon_en) begin
      exp_now = q.size() > 0 && q[0].cyc == cyc;
      chk("ready", 72'(o_rdy), 72'(exp_now));
      if (o_rdy) pulses++;
      if (exp_now) begin
        hold_row = q[0].row;
        hold_col = q[0].col;
        if (o_rdy) chk("matrix", o_mat, q[0].mat);
      end
      while (q.size() > 0 && q[0].cyc <= cyc) void'(q.pop_front());
      chk("col", 72'(o_col), 72'(hold_col));
      chk("row", 72'(o_row), 72'(hold_row));
    end

  initial begin
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst_n = 1'b1;
    mon_en = 1'b1;
    pulses = 0;
    run_frame(0, 0);
    idle(4);
    chk("white_pulses", 72'(pulses), 72'd24);
    run_frame(1, 0);
    idle(4);
`ifdef GRAYSCALE_ROUNDING_EN
    chk("red_elem", 72'(o_mat[39:32]), 72'h4D);
`else
    chk("red_elem", 72'(o_mat[39:32]), 72'h4C);
`endif
    run_frame(2, 0);
    idle(4);
    chk("ramp_last_col", 72'(o_col), 72'd6);
    for (int k = 0; k < 3 * COLS + 4; k++) drive(1, k == 0, 24'($urandom));
    run_frame(3, 0);
    idle(4);
    run_frame(3, 1);
    idle(4);
    for (int k = 0; k < 400; k++) begin
      automatic bit v = $urandom_range(0, 3) != 0;
      drive(v, v && $urandom_range(0, 40) == 0, 24'($urandom));
    end
    idle(4);
    for (int k = 0; k < COLS + 5; k++) drive(1, k == 0, 24'($urandom));
    @(negedge clk);
    mon_en = 1'b0;
    vld = 1'b0;
    fsync = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_zero("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    q.delete();
    hold_row = 0;
    hold_col = 0;
    mr = 0;
    mc = 0;
    pulses = 0;
    mon_en = 1'b1;
    run_frame(0, 0);
    idle(4);
    chk("post_rst_pulses", 72'(pulses), 72'd24);
    chk("drain", 72'(q.size()), 72'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
